// File: rtl/hdmi_pixel_timing.sv
// Raster timing generator for the text controller: free-running pixel/line counters, sync and
// data-enable aligned to the colour mapper latency, blanked RGB output stage and frame events.
module hdmi_pixel_timing #(
   parameter int H_ACT    = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACT    = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit SYNC_POL = 1'b0,
   parameter int PIPE_LAT = 0
) (
   input  logic        pixel_clk,
   input  logic        reset,
   output logic [9:0]  drawX,
   output logic [9:0]  drawY,
   input  logic [3:0]  red,
   input  logic [3:0]  green,
   input  logic [3:0]  blue,
   output logic [11:0] rgb_o,
   output logic        hsync_o,
   output logic        vsync_o,
   output logic        vde_o,
   output logic        frame_start,
   output logic        vblank_start,
   output logic [15:0] frame_cnt
);

   localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;

   // Window bounds are compared in 11 bits so an end bound of exactly 1024 still fits.
   localparam logic [10:0] H_ACT_C  = 11'(H_ACT);
   localparam logic [10:0] HS_BEG_C = 11'(H_ACT + H_FP);
   localparam logic [10:0] HS_END_C = 11'(H_ACT + H_FP + H_SYNC);
   localparam logic [10:0] V_ACT_C  = 11'(V_ACT);
   localparam logic [10:0] VS_BEG_C = 11'(V_ACT + V_FP);
   localparam logic [10:0] VS_END_C = 11'(V_ACT + V_FP + V_SYNC);
   localparam logic [9:0]  H_LAST_C = 10'(H_TOT - 1);
   localparam logic [9:0]  V_LAST_C = 10'(V_TOT - 1);
   localparam logic [9:0]  V_PRE_BLANK_C = 10'(V_ACT - 1);

   localparam logic            SYNC_IDLE = ~SYNC_POL;
   localparam logic [PIPE_LAT:0] SH_IDLE = {(PIPE_LAT + 1){SYNC_IDLE}};

   logic [9:0]          hc_r;
   logic [9:0]          vc_r;
   logic                hc_end_s;
   logic                vc_end_s;
   logic [10:0]         hc_x_s;
   logic [10:0]         vc_x_s;
   logic                vde_raw_s;
   logic                hs_raw_s;
   logic                vs_raw_s;
   logic [PIPE_LAT:0]   hs_sh_r;
   logic [PIPE_LAT:0]   vs_sh_r;
   logic [PIPE_LAT:0]   vde_sh_r;
   logic                vde_dly_s;
   logic [11:0]         rgb_r;
   logic                frame_start_r;
   logic                vblank_start_r;
   logic [15:0]         frame_cnt_r;

   // End-of-line and end-of-frame decode from the current counter state
   always_comb begin
      hc_end_s = (hc_r == H_LAST_C);
      vc_end_s = (vc_r == V_LAST_C);
      hc_x_s   = {1'b0, hc_r};
      vc_x_s   = {1'b0, vc_r};
   end

   // Free-running raster counters; the line counter advances on the last pixel of each line
   always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) begin
         hc_r <= 10'd0;
         vc_r <= 10'd0;
      end else begin
         if (hc_end_s) begin
            hc_r <= 10'd0;
            if (vc_end_s) begin
               vc_r <= 10'd0;
            end else begin
               vc_r <= vc_r + 10'd1;
            end
         end else begin
            hc_r <= hc_r + 10'd1;
         end
      end
   end

   // Undelayed sync and data-enable decode in the counter domain
   always_comb begin
      vde_raw_s = (hc_x_s < H_ACT_C) && (vc_x_s < V_ACT_C);
      if ((hc_x_s >= HS_BEG_C) && (hc_x_s < HS_END_C)) begin
         hs_raw_s = SYNC_POL;
      end else begin
         hs_raw_s = SYNC_IDLE;
      end
      if ((vc_x_s >= VS_BEG_C) && (vc_x_s < VS_END_C)) begin
         vs_raw_s = SYNC_POL;
      end else begin
         vs_raw_s = SYNC_IDLE;
      end
   end

   // Shift line of PIPE_LAT+1 stages so sync/DE leave together with the registered pixel
   always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) begin
         hs_sh_r  <= SH_IDLE;
         vs_sh_r  <= SH_IDLE;
         vde_sh_r <= '0;
      end else begin
         hs_sh_r[0]  <= hs_raw_s;
         vs_sh_r[0]  <= vs_raw_s;
         vde_sh_r[0] <= vde_raw_s;
         for (int i = 1; i <= PIPE_LAT; i++) begin
            hs_sh_r[i]  <= hs_sh_r[i-1];
            vs_sh_r[i]  <= vs_sh_r[i-1];
            vde_sh_r[i] <= vde_sh_r[i-1];
         end
      end
   end

   // The blanking decision uses DE delayed by exactly the mapper latency (no register for zero)
   generate
      if (PIPE_LAT == 0) begin : g_vde_nolat
         assign vde_dly_s = vde_raw_s;
      end else begin : g_vde_lat
         assign vde_dly_s = vde_sh_r[PIPE_LAT-1];
      end
   endgenerate

   // Pixel output register: mapper colour inside the active area, black elsewhere
   always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) begin
         rgb_r <= 12'h000;
      end else begin
         rgb_r <= vde_dly_s ? {red, green, blue} : 12'h000;
      end
   end

   // Frame and vblank events are registered on the edge that moves the counters into (0,0) / (0,V_ACT)
   always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) begin
         frame_start_r  <= 1'b0;
         vblank_start_r <= 1'b0;
         frame_cnt_r    <= 16'd0;
      end else begin
         frame_start_r  <= hc_end_s && vc_end_s;
         vblank_start_r <= hc_end_s && (vc_r == V_PRE_BLANK_C);
         if (hc_end_s && vc_end_s) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
         end
      end
   end

   assign drawX        = hc_r;
   assign drawY        = vc_r;
   assign rgb_o        = rgb_r;
   assign hsync_o      = hs_sh_r[PIPE_LAT];
   assign vsync_o      = vs_sh_r[PIPE_LAT];
   assign vde_o        = vde_sh_r[PIPE_LAT];
   assign frame_start  = frame_start_r;
   assign vblank_start = vblank_start_r;
   assign frame_cnt    = frame_cnt_r;

endmodule

// File: tb/tb_hdmi_pixel_timing.sv
// Directed bench for hdmi_pixel_timing: two instances (mapper latency 0 and 2) on a small
// 15x8 raster (120-cycle frame) so several complete frames fit in a short run.
module tb_hdmi_pixel_timing;

   localparam int HA = 8;
   localparam int HF = 2;
   localparam int HS = 3;
   localparam int HB = 2;
   localparam int VA = 4;
   localparam int VF = 1;
   localparam int VS = 2;
   localparam int VB = 1;
   localparam int HT = 15;
   localparam int VT = 8;
   localparam int FT = 120;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  red = 4'h0;
   logic [3:0]  green = 4'h0;
   logic [3:0]  blue = 4'h0;

   logic [9:0]  dx [2];
   logic [9:0]  dy [2];
   logic [11:0] rgb [2];
   logic        hso [2];
   logic        vso [2];
   logic        deo [2];
   logic        fso [2];
   logic        vbo [2];
   logic [15:0] fco [2];

   int          n = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   logic        white = 1'b0;
   logic [11:0] prev_in = 12'h000;

   always #5 clk = ~clk;

   hdmi_pixel_timing #(
      .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .SYNC_POL(1'b0), .PIPE_LAT(0)
   ) u_lat0 (
      .pixel_clk(clk), .reset(rst), .drawX(dx[0]), .drawY(dy[0]),
      .red(red), .green(green), .blue(blue), .rgb_o(rgb[0]),
      .hsync_o(hso[0]), .vsync_o(vso[0]), .vde_o(deo[0]),
      .frame_start(fso[0]), .vblank_start(vbo[0]), .frame_cnt(fco[0])
   );

   hdmi_pixel_timing #(
      .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .SYNC_POL(1'b0), .PIPE_LAT(2)
   ) u_lat2 (
      .pixel_clk(clk), .reset(rst), .drawX(dx[1]), .drawY(dy[1]),
      .red(red), .green(green), .blue(blue), .rgb_o(rgb[1]),
      .hsync_o(hso[1]), .vsync_o(vso[1]), .vde_o(deo[1]),
      .frame_start(fso[1]), .vblank_start(vbo[1]), .frame_cnt(fco[1])
   );

   // Expected raw timing for the counter state reached m cycles after reset release
   function automatic logic e_hs(int m);
      int h;
      h = m % HT;
      return ((h >= HA + HF) && (h < HA + HF + HS)) ? 1'b0 : 1'b1;
   endfunction

   function automatic logic e_vs(int m);
      int v;
      v = (m / HT) % VT;
      return ((v >= VA + VF) && (v < VA + VF + VS)) ? 1'b0 : 1'b1;
   endfunction

   function automatic logic e_de(int m);
      return ((m % HT) < HA) && (((m / HT) % VT) < VA);
   endfunction

   task automatic drive_inputs();
      if (white) {red, green, blue} = 12'hFFF;
      else       {red, green, blue} = 12'(n * 37 + 5);
   endtask

   // One clock: remember the input the DUT will latch, advance, sample at the falling edge
   task automatic step();
      prev_in = {red, green, blue};
      @(posedge clk);
      @(negedge clk);
      n++;
      drive_inputs();
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      drive_inputs();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         n_checks++; if (dx[k] !== 10'd0) begin n_fail++; $display("FAIL rst_drawX inst%0d got %0d exp 0", k, dx[k]); end
         n_checks++; if (dy[k] !== 10'd0) begin n_fail++; $display("FAIL rst_drawY inst%0d got %0d exp 0", k, dy[k]); end
         n_checks++; if (rgb[k] !== 12'h000) begin n_fail++; $display("FAIL rst_rgb inst%0d got %h exp 000", k, rgb[k]); end
         n_checks++; if (hso[k] !== 1'b1) begin n_fail++; $display("FAIL rst_hsync inst%0d got %b exp 1", k, hso[k]); end
         n_checks++; if (vso[k] !== 1'b1) begin n_fail++; $display("FAIL rst_vsync inst%0d got %b exp 1", k, vso[k]); end
         n_checks++; if (deo[k] !== 1'b0) begin n_fail++; $display("FAIL rst_vde inst%0d got %b exp 0", k, deo[k]); end
         n_checks++; if (fso[k] !== 1'b0) begin n_fail++; $display("FAIL rst_fstart inst%0d got %b exp 0", k, fso[k]); end
         n_checks++; if (vbo[k] !== 1'b0) begin n_fail++; $display("FAIL rst_vblank inst%0d got %b exp 0", k, vbo[k]); end
         n_checks++; if (fco[k] !== 16'd0) begin n_fail++; $display("FAIL rst_fcnt inst%0d got %0d exp 0", k, fco[k]); end
      end
      release_reset();
   endtask

   // Full cycle-by-cycle sweep over two frames with a changing pixel pattern
   task automatic test_frame();
      for (int s = 0; s < 250; s++) begin
         step();
         for (int k = 0; k < 2; k++) begin
            int   lat;
            int   m;
            logic ehs;
            logic evs;
            logic ede;
            logic [11:0] ergb;
            lat = 2 * k;
            if (n < lat + 1) begin
               ehs = 1'b1; evs = 1'b1; ede = 1'b0;
            end else begin
               m = n - lat - 1;
               ehs = e_hs(m); evs = e_vs(m); ede = e_de(m);
            end
            ergb = ede ? prev_in : 12'h000;
            n_checks++; if (dx[k] !== 10'(n % HT)) begin n_fail++; $display("FAIL drawX inst%0d n=%0d got %0d exp %0d", k, n, dx[k], n % HT); end
            n_checks++; if (dy[k] !== 10'((n / HT) % VT)) begin n_fail++; $display("FAIL drawY inst%0d n=%0d got %0d exp %0d", k, n, dy[k], (n / HT) % VT); end
            n_checks++; if (hso[k] !== ehs) begin n_fail++; $display("FAIL hsync inst%0d n=%0d got %b exp %b", k, n, hso[k], ehs); end
            n_checks++; if (vso[k] !== evs) begin n_fail++; $display("FAIL vsync inst%0d n=%0d got %b exp %b", k, n, vso[k], evs); end
            n_checks++; if (deo[k] !== ede) begin n_fail++; $display("FAIL vde inst%0d n=%0d got %b exp %b", k, n, deo[k], ede); end
            n_checks++; if (rgb[k] !== ergb) begin n_fail++; $display("FAIL rgb inst%0d n=%0d got %h exp %h", k, n, rgb[k], ergb); end
            n_checks++; if (fso[k] !== ((n % FT) == 0)) begin n_fail++; $display("FAIL fstart inst%0d n=%0d got %b", k, n, fso[k]); end
            n_checks++; if (vbo[k] !== ((n % FT) == VA * HT)) begin n_fail++; $display("FAIL vblank inst%0d n=%0d got %b", k, n, vbo[k]); end
            n_checks++; if (fco[k] !== 16'(n / FT)) begin n_fail++; $display("FAIL fcnt inst%0d n=%0d got %0d exp %0d", k, n, fco[k], n / FT); end
         end
      end
   endtask

   // First-line edge positions after a fresh release, hand-computed per latency
   task automatic test_sync_edges();
      int   hs_fall [2];
      int   hs_rise [2];
      int   de_rise [2];
      int   de_fall [2];
      logic hs_prev [2];
      logic de_prev [2];
      int   exp_hs_fall [2];
      int   exp_hs_rise [2];
      int   exp_de_rise [2];
      int   exp_de_fall [2];
      exp_hs_fall = '{11, 13};
      exp_hs_rise = '{14, 16};
      exp_de_rise = '{1, 3};
      exp_de_fall = '{9, 11};
      rst = 1'b1;
      @(negedge clk);
      release_reset();
      for (int k = 0; k < 2; k++) begin
         hs_fall[k] = -1; hs_rise[k] = -1; de_rise[k] = -1; de_fall[k] = -1;
         hs_prev[k] = hso[k]; de_prev[k] = deo[k];
      end
      for (int s = 0; s < 20; s++) begin
         step();
         for (int k = 0; k < 2; k++) begin
            if (hs_prev[k] && !hso[k] && hs_fall[k] < 0) hs_fall[k] = n;
            if (!hs_prev[k] && hso[k] && hs_rise[k] < 0) hs_rise[k] = n;
            if (!de_prev[k] && deo[k] && de_rise[k] < 0) de_rise[k] = n;
            if (de_prev[k] && !deo[k] && de_fall[k] < 0) de_fall[k] = n;
            hs_prev[k] = hso[k]; de_prev[k] = deo[k];
         end
      end
      for (int k = 0; k < 2; k++) begin
         n_checks++; if (hs_fall[k] != exp_hs_fall[k]) begin n_fail++; $display("FAIL hs_fall_cycle inst%0d got %0d exp %0d", k, hs_fall[k], exp_hs_fall[k]); end
         n_checks++; if (hs_rise[k] != exp_hs_rise[k]) begin n_fail++; $display("FAIL hs_rise_cycle inst%0d got %0d exp %0d", k, hs_rise[k], exp_hs_rise[k]); end
         n_checks++; if (de_rise[k] != exp_de_rise[k]) begin n_fail++; $display("FAIL de_rise_cycle inst%0d got %0d exp %0d", k, de_rise[k], exp_de_rise[k]); end
         n_checks++; if (de_fall[k] != exp_de_fall[k]) begin n_fail++; $display("FAIL de_fall_cycle inst%0d got %0d exp %0d", k, de_fall[k], exp_de_fall[k]); end
      end
   endtask

   // Constant white input over one frame-length window: pulse and pixel statistics
   task automatic test_const_white();
      int   c_white [2];
      int   c_bad [2];
      int   c_hs_low [2];
      int   c_hs_fall [2];
      int   c_vs_low [2];
      int   c_vs_fall [2];
      int   c_fs [2];
      int   c_vb [2];
      logic hs_prev [2];
      logic vs_prev [2];
      white = 1'b1;
      drive_inputs();
      while (n < 40) step();
      for (int k = 0; k < 2; k++) begin
         c_white[k] = 0; c_bad[k] = 0; c_hs_low[k] = 0; c_hs_fall[k] = 0;
         c_vs_low[k] = 0; c_vs_fall[k] = 0; c_fs[k] = 0; c_vb[k] = 0;
         hs_prev[k] = hso[k]; vs_prev[k] = vso[k];
      end
      for (int s = 0; s < FT; s++) begin
         step();
         for (int k = 0; k < 2; k++) begin
            if (rgb[k] == 12'hFFF) c_white[k]++;
            if ((rgb[k] != 12'h000) && !deo[k]) c_bad[k]++;
            if ((rgb[k] != 12'h000) && (rgb[k] != 12'hFFF)) c_bad[k]++;
            if (!hso[k]) c_hs_low[k]++;
            if (hs_prev[k] && !hso[k]) c_hs_fall[k]++;
            if (!vso[k]) c_vs_low[k]++;
            if (vs_prev[k] && !vso[k]) c_vs_fall[k]++;
            if (fso[k]) c_fs[k]++;
            if (vbo[k]) c_vb[k]++;
            hs_prev[k] = hso[k]; vs_prev[k] = vso[k];
         end
      end
      for (int k = 0; k < 2; k++) begin
         n_checks++; if (c_white[k] != 32) begin n_fail++; $display("FAIL white_pixels inst%0d got %0d exp 32", k, c_white[k]); end
         n_checks++; if (c_bad[k] != 0) begin n_fail++; $display("FAIL rgb_outside_de inst%0d got %0d exp 0", k, c_bad[k]); end
         n_checks++; if (c_hs_low[k] != 24) begin n_fail++; $display("FAIL hsync_low_cycles inst%0d got %0d exp 24", k, c_hs_low[k]); end
         n_checks++; if (c_hs_fall[k] != 8) begin n_fail++; $display("FAIL hsync_pulses inst%0d got %0d exp 8", k, c_hs_fall[k]); end
         n_checks++; if (c_vs_low[k] != 30) begin n_fail++; $display("FAIL vsync_low_cycles inst%0d got %0d exp 30", k, c_vs_low[k]); end
         n_checks++; if (c_vs_fall[k] != 1) begin n_fail++; $display("FAIL vsync_pulses inst%0d got %0d exp 1", k, c_vs_fall[k]); end
         n_checks++; if (c_fs[k] != 1) begin n_fail++; $display("FAIL fstart_pulses inst%0d got %0d exp 1", k, c_fs[k]); end
         n_checks++; if (c_vb[k] != 1) begin n_fail++; $display("FAIL vblank_pulses inst%0d got %0d exp 1", k, c_vb[k]); end
         n_checks++; if (fco[k] !== 16'd1) begin n_fail++; $display("FAIL fcnt_after_window inst%0d got %0d exp 1", k, fco[k]); end
      end
   endtask

   // Asynchronous reset at (hc=5, vc=3) of frame 2, then restart from (0,0)
   task automatic test_reset_midframe();
      while (n < 290) step();
      n_checks++; if (dx[0] !== 10'd5) begin n_fail++; $display("FAIL pre_reset_drawX got %0d exp 5", dx[0]); end
      n_checks++; if (dy[0] !== 10'd3) begin n_fail++; $display("FAIL pre_reset_drawY got %0d exp 3", dy[0]); end
      n_checks++; if (fco[1] !== 16'd2) begin n_fail++; $display("FAIL pre_reset_fcnt got %0d exp 2", fco[1]); end
      #2;
      rst = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         n_checks++; if (dx[k] !== 10'd0) begin n_fail++; $display("FAIL async_drawX inst%0d got %0d exp 0", k, dx[k]); end
         n_checks++; if (dy[k] !== 10'd0) begin n_fail++; $display("FAIL async_drawY inst%0d got %0d exp 0", k, dy[k]); end
         n_checks++; if (rgb[k] !== 12'h000) begin n_fail++; $display("FAIL async_rgb inst%0d got %h exp 000", k, rgb[k]); end
         n_checks++; if (hso[k] !== 1'b1) begin n_fail++; $display("FAIL async_hsync inst%0d got %b exp 1", k, hso[k]); end
         n_checks++; if (vso[k] !== 1'b1) begin n_fail++; $display("FAIL async_vsync inst%0d got %b exp 1", k, vso[k]); end
         n_checks++; if (deo[k] !== 1'b0) begin n_fail++; $display("FAIL async_vde inst%0d got %b exp 0", k, deo[k]); end
         n_checks++; if (fco[k] !== 16'd0) begin n_fail++; $display("FAIL async_fcnt inst%0d got %0d exp 0", k, fco[k]); end
      end
      @(negedge clk);
      release_reset();
      for (int s = 0; s < 125; s++) begin
         step();
         for (int k = 0; k < 2; k++) begin
            if (n <= 3) begin
               n_checks++; if (dx[k] !== 10'(n)) begin n_fail++; $display("FAIL restart_drawX inst%0d n=%0d got %0d", k, n, dx[k]); end
            end
            if (n < FT) begin
               n_checks++; if (fso[k] !== 1'b0) begin n_fail++; $display("FAIL early_fstart inst%0d n=%0d got %b exp 0", k, n, fso[k]); end
            end
            if (n == FT) begin
               n_checks++; if (fso[k] !== 1'b1) begin n_fail++; $display("FAIL first_fstart inst%0d got %b exp 1", k, fso[k]); end
               n_checks++; if (fco[k] !== 16'd1) begin n_fail++; $display("FAIL first_fcnt inst%0d got %0d exp 1", k, fco[k]); end
               n_checks++; if (dy[k] !== 10'd0) begin n_fail++; $display("FAIL wrap_drawY inst%0d got %0d exp 0", k, dy[k]); end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_sync_edges();
      test_const_white();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
